// File: rtl/alu_sweep_sequencer_pkg.sv
// Shared definitions for the ALU sweep sequencer: FSM state encoding, operand
// pattern nibbles, pattern-select encodings and the ALU opcode map.
package alu_sweep_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResult,
    StDone
  } state_e;

  // Nibbles replicated across the operand width to build the two patterns.
  localparam logic [3:0] NIB_1010 = 4'b1010;
  localparam logic [3:0] NIB_0101 = 4'b0101;
  localparam logic [3:0] NIB_0110 = 4'b0110;

  // Pattern A: a = 1010.., b = 0101.., carryin = 0.
  // Pattern B: a = b = 0110.., carryin = 1.
  localparam logic PAT_A = 1'b0;
  localparam logic PAT_B = 1'b1;

  // ALU opcode map; codes 12..15 produce zero on both outputs.
  localparam logic [3:0] OP_ADD  = 4'd0;   // out = a+b+cin, extra = carry out
  localparam logic [3:0] OP_SUB  = 4'd1;   // out = a-b-cin, extra = borrow out
  localparam logic [3:0] OP_AND  = 4'd2;   // out = a&b,     extra = a|b
  localparam logic [3:0] OP_XOR  = 4'd3;   // out = a^b,     extra = ~(a^b)
  localparam logic [3:0] OP_NOT  = 4'd4;   // out = ~a,      extra = ~b
  localparam logic [3:0] OP_SHL  = 4'd5;   // out = {a<<1, cin}, extra = a msb
  localparam logic [3:0] OP_SHR  = 4'd6;   // out = {cin, a>>1}, extra = a lsb
  localparam logic [3:0] OP_INC  = 4'd7;   // out = a+1,     extra = b-1
  localparam logic [3:0] OP_CMP  = 4'd8;   // out = a==b,    extra = a<b (unsigned)
  localparam logic [3:0] OP_SWAP = 4'd9;   // out = b,       extra = a
  localparam logic [3:0] OP_ANDN = 4'd10;  // out = a&~b,    extra = ~a&b
  localparam logic [3:0] OP_POPC = 4'd11;  // out = popcount(a), extra = popcount(b)

endpackage

// File: rtl/alu_sweep_sequencer_alu.sv
// Purely combinational ALU driven by the sweep sequencer.
// Ports:
//   opcode  [3:0]       operation select (see package opcode map)
//   a, b    [WIDTH-1:0] operands
//   carryin             carry/borrow/shift-in bit
//   out     [WIDTH-1:0] primary result
//   extra   [WIDTH-1:0] secondary result (flags or companion value)
module alu_sweep_sequencer_alu
  import alu_sweep_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] extra
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_pop_a;
  logic [WIDTH-1:0] w_pop_b;

  // One extra bit so the top bit carries the carry / borrow out.
  assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carryin};
  assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carryin};

  always_comb begin
    w_pop_a = '0;
    w_pop_b = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_pop_a = w_pop_a + {{(WIDTH-1){1'b0}}, a[i]};
      w_pop_b = w_pop_b + {{(WIDTH-1){1'b0}}, b[i]};
    end
  end

  always_comb begin
    out   = '0;
    extra = '0;
    case (opcode)
      OP_ADD: begin
        out   = w_sum[WIDTH-1:0];
        extra = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
      end
      OP_SUB: begin
        out   = w_diff[WIDTH-1:0];
        extra = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
      end
      OP_AND: begin
        out   = a & b;
        extra = a | b;
      end
      OP_XOR: begin
        out   = a ^ b;
        extra = ~(a ^ b);
      end
      OP_NOT: begin
        out   = ~a;
        extra = ~b;
      end
      OP_SHL: begin
        out   = {a[WIDTH-2:0], carryin};
        extra = {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
      end
      OP_SHR: begin
        out   = {carryin, a[WIDTH-1:1]};
        extra = {{(WIDTH-1){1'b0}}, a[0]};
      end
      OP_INC: begin
        out   = a + One;
        extra = b - One;
      end
      OP_CMP: begin
        out   = {{(WIDTH-1){1'b0}}, (a == b)};
        extra = {{(WIDTH-1){1'b0}}, (a < b)};
      end
      OP_SWAP: begin
        out   = b;
        extra = a;
      end
      OP_ANDN: begin
        out   = a & ~b;
        extra = ~a & b;
      end
      OP_POPC: begin
        out   = w_pop_a;
        extra = w_pop_b;
      end
      default: begin
        out   = '0;
        extra = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Sweep sequencer: on a start pulse, drives the ALU through every opcode
// 0..NUM_OPS-1 with operand pattern A then B, captures each out/extra and
// offers it on a valid/ready result port.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, abort         begin a sweep (when idle) / cancel a running sweep
//   res_ready/res_valid  result handshake
//   res_opcode/pattern   which step produced the current result
//   res_out/res_extra    captured ALU outputs
//   busy, done           not idle / one-cycle completion pulse
//   step_count           results accepted in the current or last sweep
module alu_sweep_sequencer
  import alu_sweep_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [3:0]       res_opcode,
  output logic             res_pattern,
  output logic [WIDTH-1:0] res_out,
  output logic [WIDTH-1:0] res_extra,
  output logic             busy,
  output logic             done,
  output logic [4:0]       step_count
);

  localparam logic [3:0]       LastOp   = 4'(NUM_OPS - 1);
  localparam logic [WIDTH-1:0] PAT_A_A  = {(WIDTH/4){NIB_1010}};
  localparam logic [WIDTH-1:0] PAT_A_B  = {(WIDTH/4){NIB_0101}};
  localparam logic [WIDTH-1:0] PAT_B_AB = {(WIDTH/4){NIB_0110}};

  state_e           r_state, w_state_next;
  logic [3:0]       r_opcode;
  logic             r_pattern;
  logic [3:0]       r_alu_opcode;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic             r_alu_cin;
  logic [3:0]       r_res_opcode;
  logic             r_res_pattern;
  logic [WIDTH-1:0] r_res_out, r_res_extra;
  logic [4:0]       r_step_count;

  logic [WIDTH-1:0] w_alu_out, w_alu_extra;
  logic             w_launch, w_clear, w_capture, w_accept, w_last;
  logic [3:0]       w_opcode_next;
  logic             w_pattern_next;

  alu_sweep_sequencer_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .opcode (r_alu_opcode),
    .a      (r_alu_a),
    .b      (r_alu_b),
    .carryin(r_alu_cin),
    .out    (w_alu_out),
    .extra  (w_alu_extra)
  );

  assign w_last = (r_opcode == LastOp) && (r_pattern == PAT_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_launch       = 1'b0;
    w_clear        = 1'b0;
    w_capture      = 1'b0;
    w_accept       = 1'b0;
    w_opcode_next  = r_opcode;
    w_pattern_next = r_pattern;
    res_valid      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start && !abort) begin
          w_state_next   = StIssue;
          w_launch       = 1'b1;
          w_clear        = 1'b1;
          w_opcode_next  = 4'd0;
          w_pattern_next = PAT_A;
        end
      end
      StIssue: begin
        if (abort) begin
          w_state_next = StIdle;
        end else begin
          w_capture    = 1'b1;
          w_state_next = StResult;
        end
      end
      StResult: begin
        res_valid = 1'b1;
        // Abort wins over a simultaneous handshake: the result is dropped.
        if (abort) begin
          w_state_next = StIdle;
        end else if (res_ready) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StIssue;
            w_launch     = 1'b1;
            if (r_pattern == PAT_B) begin
              w_opcode_next  = r_opcode + 4'd1;
              w_pattern_next = PAT_A;
            end else begin
              w_pattern_next = PAT_B;
            end
          end
        end
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode      <= '0;
      r_pattern     <= PAT_A;
      r_alu_opcode  <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_cin     <= 1'b0;
      r_res_opcode  <= '0;
      r_res_pattern <= 1'b0;
      r_res_out     <= '0;
      r_res_extra   <= '0;
      r_step_count  <= '0;
    end else begin
      // ALU inputs change only on entry to ISSUE, so they are stable all cycle.
      if (w_launch) begin
        r_opcode     <= w_opcode_next;
        r_pattern    <= w_pattern_next;
        r_alu_opcode <= w_opcode_next;
        r_alu_a      <= (w_pattern_next == PAT_B) ? PAT_B_AB : PAT_A_A;
        r_alu_b      <= (w_pattern_next == PAT_B) ? PAT_B_AB : PAT_A_B;
        r_alu_cin    <= (w_pattern_next == PAT_B);
      end
      if (w_capture) begin
        r_res_opcode  <= r_opcode;
        r_res_pattern <= r_pattern;
        r_res_out     <= w_alu_out;
        r_res_extra   <= w_alu_extra;
      end
      if (w_clear) begin
        r_step_count <= '0;
      end else if (w_accept) begin
        r_step_count <= r_step_count + 5'd1;
      end
    end
  end

  assign res_opcode  = r_res_opcode;
  assign res_pattern = r_res_pattern;
  assign res_out     = r_res_out;
  assign res_extra   = r_res_extra;
  assign step_count  = r_step_count;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
module tb_alu_sweep_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 12-opcode instance
  logic        reset, start, abort, res_ready;
  logic        res_valid, res_pattern, busy, done;
  logic [3:0]  res_opcode;
  logic [31:0] res_out, res_extra;
  logic [4:0]  step_count;

  // 8-bit, 1-opcode instance
  logic        s_reset, s_start, s_abort, s_res_ready;
  logic        s_res_valid, s_res_pattern, s_busy, s_done;
  logic [3:0]  s_res_opcode;
  logic [7:0]  s_res_out, s_res_extra;
  logic [4:0]  s_step_count;

  alu_sweep_sequencer #(.WIDTH(32), .NUM_OPS(12)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .res_ready(res_ready),
    .res_valid(res_valid), .res_opcode(res_opcode), .res_pattern(res_pattern),
    .res_out(res_out), .res_extra(res_extra), .busy(busy), .done(done),
    .step_count(step_count)
  );

  alu_sweep_sequencer #(.WIDTH(8), .NUM_OPS(1)) dut8 (
    .clk(clk), .reset(s_reset), .start(s_start), .abort(s_abort), .res_ready(s_res_ready),
    .res_valid(s_res_valid), .res_opcode(s_res_opcode), .res_pattern(s_res_pattern),
    .res_out(s_res_out), .res_extra(s_res_extra), .busy(s_busy), .done(s_done),
    .step_count(s_step_count)
  );

  int checks = 0;
  int errors = 0;

  // Hand-computed ALU results, index = 2*opcode + pattern.
  logic [31:0] exp_out [24] = '{
    32'hFFFFFFFF, 32'hCCCCCCCD, 32'h55555555, 32'hFFFFFFFF,
    32'h00000000, 32'h66666666, 32'hFFFFFFFF, 32'h00000000,
    32'h55555555, 32'h99999999, 32'h55555554, 32'hCCCCCCCD,
    32'h55555555, 32'hB3333333, 32'hAAAAAAAB, 32'h66666667,
    32'h00000000, 32'h00000001, 32'h55555555, 32'h66666666,
    32'hAAAAAAAA, 32'h00000000, 32'h00000010, 32'h00000010
  };
  logic [31:0] exp_extra [24] = '{
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001,
    32'hFFFFFFFF, 32'h66666666, 32'h00000000, 32'hFFFFFFFF,
    32'hAAAAAAAA, 32'h99999999, 32'h00000001, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h55555554, 32'h66666665,
    32'h00000000, 32'h00000000, 32'hAAAAAAAA, 32'h66666666,
    32'h55555555, 32'h00000000, 32'h00000010, 32'h00000010
  };

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep on the 32-bit instance. Cycle 1 is the cycle after the edge
  // that samples start. stop_kind: 0 none, 1 abort, 2 reset when result
  // number stop_at is presented.
  task automatic sweep(input int busy_start_cyc, input int stall_at, input int stall_len,
                       input int stop_kind, input int stop_at, input int exp_done_cyc);
    int cyc, got, stalled;
    bit fin;
    logic [68:0] held;
    cyc = 1; got = 0; stalled = 0; fin = 0; held = '0;
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc <= 150) begin
      if (cyc == 1) begin
        chk("issue_a", dut.r_alu_a, 32'hAAAAAAAA);
        chk("issue_b", dut.r_alu_b, 32'h55555555);
        chk("issue_cin_op", {dut.r_alu_cin, dut.r_alu_opcode}, 5'h00);
        chk("issue_busy", busy, 1'b1);
      end
      start = (cyc == busy_start_cyc);
      res_ready = 1'b1;
      if (res_valid) begin
        if (stop_kind != 0 && got == stop_at) begin
          res_ready = 1'b0;
          if (stop_kind == 1) abort = 1'b1;
          else reset = 1'b1;
          tick();
          abort = 1'b0;
          reset = 1'b0;
          chk("stop_busy", busy, 1'b0);
          chk("stop_valid", res_valid, 1'b0);
          chk("stop_done", done, 1'b0);
          chk("stop_count", step_count, (stop_kind == 1) ? 5'(stop_at) : 5'd0);
          if (stop_kind == 2) begin
            chk("rst_res", {res_opcode, res_pattern, res_out, res_extra}, 69'd0);
            chk("rst_drive", {dut.r_alu_a, dut.r_alu_b, dut.r_alu_cin}, 65'd0);
          end
          tick();
          chk("stop_no_done", {done, busy}, 2'b00);
          fin = 1;
        end else if (got == stall_at && stalled < stall_len) begin
          if (stalled == 0) held = {res_opcode, res_pattern, res_out, res_extra};
          else chk("stall_hold", {res_opcode, res_pattern, res_out, res_extra}, held);
          res_ready = 1'b0;
          stalled++;
        end else begin
          chk("result", {res_opcode, res_pattern, res_out, res_extra},
              {4'(got / 2), 1'(got % 2), exp_out[got], exp_extra[got]});
          got++;
        end
      end
      if (!fin) begin
        if (done) begin
          chk("done_cycle", cyc, exp_done_cyc);
          chk("done_count", step_count, 5'd24);
          chk("done_results", got, 24);
          if (stall_len > 0) chk("stall_cycles", stalled, stall_len);
          tick();
          chk("done_pulse", {done, busy, res_valid}, 3'b000);
          chk("count_hold", step_count, 5'd24);
          fin = 1;
        end else begin
          tick();
          cyc++;
        end
      end
    end
    if (!fin) chk("sweep_timeout", 1'b0, 1'b1);
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    s_reset = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_res_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    s_reset = 1'b0;
    chk("rst_ctrl", {busy, done, res_valid, step_count}, 8'd0);
    chk("rst_res", {res_opcode, res_pattern, res_out, res_extra}, 69'd0);
    chk("rst8_all", {s_busy, s_done, s_res_valid, s_step_count, s_res_opcode, s_res_pattern,
                     s_res_out, s_res_extra}, 29'd0);

    // Full sweep, ready high
    sweep(-1, -1, 0, 0, 0, 49);
    // Backpressure on op1/B for 5 cycles
    sweep(-1, 3, 5, 0, 0, 54);
    // Abort after 7 accepted results, then restart
    sweep(-1, -1, 0, 1, 7, 0);
    sweep(-1, -1, 0, 0, 0, 49);
    // Start pulsed while busy is ignored
    sweep(10, -1, 0, 0, 0, 49);

    // Abort beats a simultaneous start in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_prio", {busy, step_count}, {1'b0, 5'd24});

    // Reset while a result is pending, then a complete sweep
    sweep(-1, -1, 0, 2, 4, 0);
    sweep(-1, -1, 0, 0, 0, 49);

    // NUM_OPS=1, WIDTH=8 boundary
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("b8_c1_drive", {dut8.r_alu_a, dut8.r_alu_b, dut8.r_alu_cin}, {8'hAA, 8'h55, 1'b0});
    chk("b8_c1_busy", {s_busy, s_res_valid}, 2'b10);
    tick();
    chk("b8_c2_res", {s_res_valid, s_res_opcode, s_res_pattern, s_res_out, s_res_extra},
        {1'b1, 4'd0, 1'b0, 8'hFF, 8'h00});
    tick();
    chk("b8_c3_drive", {dut8.r_alu_a, dut8.r_alu_b, dut8.r_alu_cin}, {8'h66, 8'h66, 1'b1});
    chk("b8_c3_valid", s_res_valid, 1'b0);
    tick();
    chk("b8_c4_res", {s_res_valid, s_res_opcode, s_res_pattern, s_res_out, s_res_extra},
        {1'b1, 4'd0, 1'b1, 8'hCD, 8'h00});
    tick();
    chk("b8_c5_done", {s_done, s_step_count}, {1'b1, 5'd2});
    tick();
    chk("b8_c6_idle", {s_done, s_busy, s_step_count}, {1'b0, 1'b0, 5'd2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sweep_sequencer.md
Name: alu_sweep_sequencer

Overview:
- Clocked driver that sits in front of the combinational ALU and issues operations to it.
- On a start pulse it walks every opcode 0..NUM_OPS-1 with two fixed operand patterns.
- It captures the ALU's out/extra for each step and presents each result on a valid/ready result port, so a checker or logger consumes ALU results at its own pace.
- The ALU is instantiated inside this block. This block is the producer of opcode/a/b/carryin; the ALU is the consumer.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of 4.
- NUM_OPS, 12, number of opcodes swept (0..NUM_OPS-1). Must be ≤16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a sweep when idle.
- abort  input  1  terminates a sweep in progress.
- res_ready  input  1  consumer accepts the current result.
- res_valid  output  1  result registers hold an unconsumed result.
- res_opcode  output  4  opcode that produced the result.
- res_pattern  output  1  0 = pattern A, 1 = pattern B.
- res_out  output  WIDTH  captured ALU out.
- res_extra  output  WIDTH  captured ALU extra.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last result is accepted.
- step_count  output  5  number of results accepted in the current or last sweep.

Behaviour:
- Reset: synchronous, active-high. Clock is clk, reset is reset. On reset, next edge gives:
  - state = IDLE
  - every output = 0
  - internal opcode/pattern counters = 0
  - ALU drive registers = 0
  - reset wins over start and abort, including mid-sweep.
- Patterns:
  - A: a = {WIDTH/4{4'b1010}}, b = {WIDTH/4{4'b0101}}, carryin = 0.
  - B: a = b = {WIDTH/4{4'b0110}}, carryin = 1.
- Order: op0/A, op0/B, op1/A, op1/B, … op(NUM_OPS-1)/B. Total 2*NUM_OPS steps.
- FSM states are IDLE, ISSUE, RESULT, DONE.
- IDLE:
  - start=1 and abort=0 → ISSUE; step_count cleared, opcode=0, pattern=0.
  - start while not IDLE is ignored.
- ISSUE (1 cycle):
  - ALU drive registers are loaded at entry to ISSUE, so ALU inputs are stable for this whole cycle.
  - At the end of the cycle, out/extra/opcode/pattern are registered into the res_* registers; next state is RESULT.
- RESULT:
  - res_valid = 1. res_* are held stable while res_valid=1 and res_ready=0.
  - res_ready=1: step_count += 1 and res_valid drops on the next edge.
  - On that same handshake: if this was the last step → DONE; else advance pattern (B → A with opcode+1) and go to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE. step_count holds 2*NUM_OPS until the next start.
- Latency and throughput:
  - start sampled at edge 0 → ISSUE in cycle 1 → res_valid high from cycle 2.
  - With res_ready tied high: one result every 2 cycles; done is asserted 4*NUM_OPS+1 cycles after start is sampled.
- Abort:
  - In ISSUE or RESULT → IDLE on the next edge.
  - res_valid drops to 0, no done pulse, step_count keeps the accepted count.
  - In IDLE, abort has priority over a simultaneous start (stay IDLE).
  - In DONE, abort is ignored; the done pulse still completes.
- ALU is purely combinational. No width growth: res_out and res_extra are exactly WIDTH bits.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, ISSUE, RESULT, DONE}
  - pattern nibble constants 4'b1010, 4'b0101, 4'b0110
  - PAT_A / PAT_B encodings
- Sub-module: the existing ALU, instantiated once with WIDTH passed through. No other sub-modules.

Test Plan:
- Full sweep, res_ready held 1, WIDTH=32, reset released, start pulse:
  - 24 results in order (op0/A, op0/B, …, op11/B).
  - First result: res_opcode=0, res_pattern=0, with ALU inputs a=0xAAAAAAAA, b=0x55555555, carryin=0.
  - res_out/res_extra equal the ALU reference model for each step.
  - done pulses 49 cycles after start; step_count=24.
- Backpressure: hold res_ready=0 for 5 cycles at step 3 (op1/B):
  - res_valid stays 1 and res_* are unchanged throughout.
  - The sweep resumes, and done is delayed by exactly 5 cycles.
- Abort mid-sweep: abort asserted while in RESULT after 7 accepted results:
  - Next cycle: busy=0, res_valid=0, step_count=7, no done.
  - A following start restarts at op0/A.
- Start while busy: start pulsed in the 10th cycle of a sweep → ignored; ordering and count (24) are unaffected.
- Reset in RESULT with res_valid=1 → next edge: all outputs 0, state IDLE. A start 2 cycles later runs a complete sweep.
- Boundary: NUM_OPS=1, WIDTH=8:
  - Exactly 2 results, the first with a=0xAA, b=0x55 and the second with a=b=0x66, carryin=1.
  - done on cycle 5; step_count=2.
